// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory program loader and for any
//   assembler model that builds instruction words.
//   - op_mne      : 3-bit opcode mnemonics as seen by the control decoder
//   - INST_W      : encoded instruction width (opcode in [5:3], operand in [2:0])
//   - encode_inst : packs a mnemonic and operand into one instruction word
package imem_loader_pkg;

  localparam int OP_W   = 3;
  localparam int ARG_W  = 3;
  localparam int INST_W = OP_W + ARG_W;

  // The decoder tells sw from lw through the operand of kLSW
  // (zero = sw, nonzero = lw), so the loader never rewrites operands.
  typedef enum logic [OP_W-1:0] {
    kNOP = 3'd0,
    kSET = 3'd1,
    kADD = 3'd2,
    kSUB = 3'd3,
    kLSW = 3'd4,
    kJMP = 3'd5,
    kBEQ = 3'd6,
    kOUT = 3'd7
  } op_mne;

  function automatic logic [INST_W-1:0] encode_inst(input op_mne op,
                                                    input logic [ARG_W-1:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader
//   Program-load front end for the instruction memory. Accepts a stream of
//   (mnemonic, operand) beats, encodes each into a 6-bit instruction word and
//   writes the words to consecutive instruction-memory addresses starting at 0.
//   Reports completion (done), overflow (error) and the number of words written.
//
// Ports
//   clk          : system clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : begin a new load (honoured in IDLE, DONE, ERR only)
//   in_valid     : beat present on in_op / in_arg / in_last
//   in_ready     : loader accepts a beat this cycle
//   in_op        : opcode mnemonic
//   in_arg       : operand field
//   in_last      : final beat of the program
//   mem_wr_en    : instruction-memory write strobe (one cycle per accepted beat)
//   mem_wr_addr  : write address
//   mem_wr_data  : encoded instruction word
//   done         : load finished cleanly, held until the next start
//   error        : load overflowed the memory, held until the next start
//   count        : words written in the current load (0..DEPTH)
//   state_dbg    : current loader state (IDLE=0, LOAD=1, DONE=2, ERR=3)
//
// Handshake: a beat transfers on a rising clock edge where in_valid && in_ready
// are both high. in_ready depends only on the loader state, never on in_valid,
// and the producer must hold a beat stable until it transfers.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_mne             in_op,
  input  logic [ARG_W-1:0]  in_arg,
  input  logic              in_last,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [INST_W-1:0] mem_wr_data,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [INST_W-1:0]   wr_data_q;

  logic accept;
  logic go;
  logic at_end;

  assign at_end = (ptr_q == PTR_LAST);

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    go      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          go      = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        accept = in_valid;
        if (in_valid) begin
          // in_last wins over overflow on the final memory word.
          if (in_last) begin
            state_d = S_DONE;
          end else if (at_end) begin
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write pointer, word counter and the registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (go) begin
        ptr_q   <= '0;
        count_q <= '0;
      end
      if (accept) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= encode_inst(in_op, in_arg);
        count_q   <= count_q + CNT_ONE;
        // Pointer saturates at the last word; the state machine stops
        // accepting there, so nothing ever wraps back to address 0.
        if (!at_end) begin
          ptr_q <= ptr_q + PTR_ONE;
        end
      end
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign count       = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Two loader instances share one stimulus stream: a wide one (ADDR_W = 8,
//   256 words) and a tiny one (ADDR_W = 2, 4 words) so that the overflow and
//   last-word boundaries are reached quickly. A reference model per instance
//   tracks the load session (loading / done / overflowed, next address, word
//   count) and queues the expected memory writes; a negedge monitor compares
//   status outputs every cycle and pops the queue on every write strobe.
module tb_imem_loader;
  import imem_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  op_mne      in_op = kNOP;
  logic [2:0] in_arg = 3'd0;

  logic       rdy_a, en_a, done_a, err_a;
  logic [7:0] addr_a;
  logic [5:0] data_a;
  logic [8:0] cnt_a;
  logic [1:0] st_a;

  logic       rdy_b, en_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [5:0] data_b;
  logic [2:0] cnt_b;
  logic [1:0] st_b;

  imem_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy_a), .in_op(in_op), .in_arg(in_arg), .in_last(in_last),
    .mem_wr_en(en_a), .mem_wr_addr(addr_a), .mem_wr_data(data_a),
    .done(done_a), .error(err_a), .count(cnt_a), .state_dbg(st_a)
  );

  imem_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy_b), .in_op(in_op), .in_arg(in_arg), .in_last(in_last),
    .mem_wr_en(en_b), .mem_wr_addr(addr_b), .mem_wr_data(data_b),
    .done(done_b), .error(err_b), .count(cnt_b), .state_dbg(st_b)
  );

  // ---------------- counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int  depth [2] = '{256, 4};
  bit  m_load[2];
  bit  m_done[2];
  bit  m_err [2];
  bit  m_wr  [2];
  int  m_ptr [2];
  int  m_cnt [2];
  logic [13:0] exp_q0[$];   // {addr[7:0], word[5:0]}
  logic [13:0] exp_q1[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_load[i] = 0; m_done[i] = 0; m_err[i] = 0; m_wr[i] = 0;
        m_ptr[i] = 0; m_cnt[i] = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_wr[i] = 0;
        if (!m_load[i]) begin
          if (start) begin
            m_load[i] = 1; m_done[i] = 0; m_err[i] = 0;
            m_ptr[i] = 0; m_cnt[i] = 0;
          end
        end else if (in_valid) begin
          logic [13:0] item;
          int word;
          word = int'(in_op) * 8 + int'(in_arg);
          item = {8'(m_ptr[i]), 6'(word)};
          if (i == 0) exp_q0.push_back(item);
          else        exp_q1.push_back(item);
          m_wr[i] = 1;
          m_cnt[i]++;
          if (in_last) begin
            m_load[i] = 0; m_done[i] = 1;
          end else if (m_ptr[i] == depth[i] - 1) begin
            m_load[i] = 0; m_err[i] = 1;
          end else begin
            m_ptr[i]++;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int i, input logic rdy, input logic en,
                     input logic [7:0] addr, input logic [5:0] data,
                     input logic dn, input logic er, input logic [31:0] cnt);
    logic [13:0] item;
    check("in_ready", i, {31'd0, rdy}, {31'd0, m_load[i]});
    check("done",     i, {31'd0, dn},  {31'd0, m_done[i]});
    check("error",    i, {31'd0, er},  {31'd0, m_err[i]});
    check("count",    i, cnt, m_cnt[i]);
    check("mem_wr_en", i, {31'd0, en}, {31'd0, m_wr[i]});
    if (m_wr[i]) begin
      if (i == 0) item = exp_q0.pop_front();
      else        item = exp_q1.pop_front();
      if (en === 1'b1) begin
        check("mem_wr_addr", i, {24'd0, addr}, {24'd0, item[13:6]});
        check("mem_wr_data", i, {26'd0, data}, {26'd0, item[5:0]});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rdy_a, en_a, addr_a, data_a, done_a, err_a, {23'd0, cnt_a});
    mon(1, rdy_b, en_b, {6'd0, addr_b}, data_b, done_b, err_b, {29'd0, cnt_b});
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit s, input bit v, input bit l,
                     input int op, input int a);
    @(posedge clk);
    #1;
    start    = s;
    in_valid = v;
    in_last  = l;
    in_op    = op_mne'(3'(op));
    in_arg   = 3'(a);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic beat(input bit l);
    cyc(0, 1, l, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready", 0, {31'd0, rdy_a}, 0);
    check("reset_en",    0, {31'd0, en_a}, 0);
    check("reset_addr",  0, {24'd0, addr_a}, 0);
    check("reset_data",  0, {26'd0, data_a}, 0);
    check("reset_count", 1, {29'd0, cnt_b}, 0);
    check("reset_done",  1, {31'd0, done_b | err_b}, 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Directed three-beat program.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, int'(kSET), 5);
    cyc(0, 1, 0, int'(kADD), 2);
    cyc(0, 1, 1, int'(kLSW), 0);
    idle(3);

    // Valid toggled every other cycle.
    cyc(1, 0, 0, 0, 0);
    begin
      int n = int'($urandom_range(6, 14));
      for (int k = 0; k < n; k++) begin
        beat(k == n - 1);
        idle(1);
      end
    end
    idle(3);

    // Five beats without last (small memory overflows on the 4th), then last.
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) beat(0);
    beat(1);
    idle(3);

    // Fourth beat carries last: small memory completes exactly full.
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) beat(k == 3);
    idle(3);

    // Start during LOAD is ignored; start after DONE restarts at address 0.
    cyc(1, 0, 0, 0, 0);
    beat(0);
    cyc(1, 1, 0, int'(kSUB), 3);
    cyc(1, 0, 0, 0, 0);
    beat(1);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    beat(1);
    idle(3);

    // Beats presented outside LOAD are dropped.
    for (int k = 0; k < 3; k++) beat(0);
    idle(2);

    // Random mix of starts, valid density and last markers.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    idle(3);

    // Reset asserted in the cycle following an accepted beat.
    cyc(1, 0, 0, 0, 0);
    beat(0);
    idle(0);
    @(posedge clk);
    #2;
    check("pre_reset_en", 0, {31'd0, en_a}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_en",    0, {31'd0, en_a}, 0);
    check("async_rst_en",    1, {31'd0, en_b}, 0);
    check("async_rst_count", 0, {23'd0, cnt_a}, 0);
    check("async_rst_ready", 0, {31'd0, rdy_a}, 0);
    check("async_rst_state", 0, {30'd0, st_a}, 0);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // One more clean load after reset.
    cyc(1, 0, 0, 0, 0);
    beat(0);
    beat(1);
    idle(3);

    check("queue_empty", 0, exp_q0.size(), 0);
    check("queue_empty", 1, exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-load front end for the instruction memory: accepts a stream of (mnemonic, 3-bit operand) beats over a valid/ready handshake, encodes each into the 6-bit instruction word the control decoder consumes (opcode in bits [5:3], operand in bits [2:0]), and writes the words to consecutive instruction-memory addresses. It sits between the test harness/host port and the instruction memory write port. It also reports completion, word count and overflow.

## Interface
- ADDR_W, 8: instruction-memory address width; DEPTH = 2**ADDR_W words.
- Clk  input  1  system clock, all state on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  begin a new load; honoured only in IDLE, DONE or ERR.
- InValid  input  1  beat present on InOp/InArg/InLast.
- InReady  output  1  loader can accept a beat this cycle.
- InOp  input  3  opcode, typed op_mne.
- InArg  input  3  operand field.
- InLast  input  1  final beat of the program.
- MemWrEn  output  1  instruction-memory write strobe.
- MemWrAddr  output  ADDR_W  write address.
- MemWrData  output  6  encoded instruction.
- Done  output  1  load finished cleanly; held until next Start.
- Error  output  1  overflow; held until next Start.
- Count  output  ADDR_W+1  words written in current load.

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset -> IDLE.
- IDLE/DONE/ERR + Start: clear write pointer, Count, Done, Error; go to LOAD.
- LOAD: InReady = 1. Beat accepted when InValid && InReady.
- Encoding: MemWrData = {InOp, InArg}, no translation; sw/lw distinction stays carried by the operand (zero = sw, nonzero = lw), identical to decoder rules.
- Each accepted beat: write at pointer, pointer += 1, Count += 1.
- Accepted beat with InLast = 1: -> DONE, Done = 1.
- Accepted beat at pointer == DEPTH-1 with InLast = 0: word still written, -> ERR, Error = 1. No wrap-around; pointer never exceeds DEPTH-1. InLast on that same beat -> DONE, not ERR.
- Start in LOAD is ignored. InValid outside LOAD is ignored, with no side effects.
- Count range 0..DEPTH.

## Timing
- Reset values: InReady 0, MemWrEn 0, MemWrAddr 0, MemWrData 0, Done 0, Error 0, Count 0.
- Start sampled at cycle N -> InReady = 1 at N+1.
- Beat accepted at cycle N -> MemWrEn, MemWrAddr, MemWrData registered and valid for exactly cycle N+1. Count updates at N+1.
- Back-to-back beats: one write per cycle, full throughput, no bubbles.
- Last or overflow beat at N: InReady = 0 from N+1, and Done or Error = 1 from N+1, coincident with the final MemWrEn.
- MemWrEn is 0 in every cycle not following an accepted beat. MemWrAddr and MemWrData hold their last value.
- Reset_n low mid-load: all outputs go to reset values immediately. An in-flight write is dropped (MemWrEn forced 0).

## Structure
- Shared definitions package:
  - op_mne enum.
  - Instruction width (6), opcode/operand field widths (3/3).
  - A pack function encode_inst(op_mne, logic [2:0]) used here and by any assembler model.
- Loader state enum is local to the module.
- Single module, no sub-modules; the pointer/counter is inline.

## Test plan
- Reset, Start, 3 beats (kSET/3'b101, kADD/3'b010, kLSW/3'b000 with InLast) -> writes at addr 0,1,2 with data {kSET,101}, {kADD,010}, {kLSW,000} on consecutive cycles; Done = 1 with the third write; Count = 3; InReady = 0 afterward.
- InValid toggled every other cycle -> writes only in cycles following acceptance; addresses contiguous; no duplicates.
- ADDR_W = 2, 5 beats without InLast -> 4 writes (addr 0..3), 4th beat raises Error, Count = 4, 5th beat not accepted, no wrap to addr 0.
- ADDR_W = 2, 4th beat carries InLast -> Done = 1, Error = 0, Count = 4.
- Start pulsed during LOAD -> ignored, pointer continues. Start after DONE -> Done and Count clear, next write at addr 0.
- Reset_n asserted the cycle after a beat is accepted -> MemWrEn = 0 immediately; state IDLE; Count = 0.
